// File: rtl/sr_pkg.sv
// Shared state type and S/R drive encodings for the SR latch driver.
// SR_DRIVER_VERIFY_EN adds the CHECK state used for read-back verification.
package sr_pkg;

`ifdef SR_DRIVER_VERIFY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } sr_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } sr_state_t;
`endif

  // Drive encodings as {S, R}.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_RST  = 2'b01;

  function automatic logic [1:0] sr_drive(input logic val);
    return val ? SR_SET : SR_RST;
  endfunction

endpackage

// File: rtl/sr_cycle_counter.sv
// 4-bit load/decrement counter with zero flag; times both the PULSE and SETTLE phases.
module sr_cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/sr_latch_driver.sv
// Pulse-drives an external SR latch to a requested value, optionally verifying via read-back.
// Define SR_DRIVER_VERIFY_EN to enable the CHECK state, retries and err reporting.
module sr_latch_driver #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic busy,
  output logic done,
  output logic err
);

  import sr_pkg::*;

  // Counter holds "cycles remaining minus one", so zero marks the last cycle of a phase.
  localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  sr_state_t  state_r, next_state_s;
  logic       val_r, next_val_s;
  logic [1:0] sr_r;
  logic       ready_r, busy_r, done_r, err_r;
  logic       done_s, err_s;
  logic       cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [3:0] cnt_load_val_s;

`ifdef SR_DRIVER_VERIFY_EN
  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);
  logic [2:0] retry_r, next_retry_s;
  logic       fb_pass_s;
  // Equal Q/Qbar never passes: both must match the target complementarily.
  assign fb_pass_s = (q_fb == val_r) && (qbar_fb == ~val_r);
`else
  logic unused_fb_s;
  assign unused_fb_s = q_fb ^ qbar_fb ^ (^3'(MAX_RETRY));
`endif

  sr_cycle_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, counter control and completion strobes.
  always_comb begin
    next_state_s   = state_r;
    next_val_s     = val_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = 4'd0;
    cnt_dec_s      = 1'b0;
    done_s         = 1'b0;
    err_s          = 1'b0;
`ifdef SR_DRIVER_VERIFY_EN
    next_retry_s   = retry_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req_valid && ready_r) begin
          next_state_s   = ST_PULSE;
          next_val_s     = req_val;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = PULSE_LOAD;
`ifdef SR_DRIVER_VERIFY_EN
          next_retry_s   = 3'd0;
`endif
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          next_state_s   = ST_SETTLE;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = SETTLE_LOAD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
`ifdef SR_DRIVER_VERIFY_EN
          next_state_s = ST_CHECK;
`else
          next_state_s = ST_IDLE;
          done_s       = 1'b1;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
`ifdef SR_DRIVER_VERIFY_EN
      ST_CHECK: begin
        if (fb_pass_s) begin
          next_state_s = ST_IDLE;
          done_s       = 1'b1;
        end else if (retry_r < MAX_RETRY_C) begin
          next_state_s   = ST_PULSE;
          next_retry_s   = retry_r + 3'd1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = PULSE_LOAD;
        end else begin
          next_state_s = ST_IDLE;
          err_s        = 1'b1;
        end
      end
`endif
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, captured target and outputs registered from the next state so S/R track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      val_r   <= 1'b0;
      sr_r    <= SR_HOLD;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      val_r   <= next_val_s;
      sr_r    <= (next_state_s == ST_PULSE) ? sr_drive(next_val_s) : SR_HOLD;
      ready_r <= (next_state_s == ST_IDLE);
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

`ifdef SR_DRIVER_VERIFY_EN
  // Retry attempt counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_r <= 3'd0;
    end else begin
      retry_r <= next_retry_s;
    end
  end
`endif

  assign S         = sr_r[1];
  assign R         = sr_r[0];
  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch; expectations follow SR_DRIVER_VERIFY_EN.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic q_fb, qbar_fb;
  logic req_ready, S, R, busy, done, err;

  int   tests = 0;
  int   fails = 0;
  int   overlap = 0;
  logic q_lat = 1'b0;
  int   fb_mode = 0;
  logic stuck_val = 1'b0;
  logic rand_q = 1'b0;
  logic rand_qb = 1'b0;

  typedef struct {
    logic s, r, busy, ready, done, err;
  } trace_t;

  typedef struct {
    logic val;
    int   fb_mode;
    logic stuck_val;
    int   clear_at;
    int   exp_s, exp_r, exp_pulses, exp_done, exp_err, exp_end;
  } txn_t;

`ifdef SR_DRIVER_VERIFY_EN
  localparam int N_VEC = 6;
`else
  localparam int N_VEC = 7;
`endif

  trace_t tr[6];
  txn_t   vec[N_VEC];

  always #5 clk = ~clk;

  sr_latch_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_val   (req_val),
    .req_ready (req_ready),
    .S         (S),
    .R         (R),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // External latch: set dominates nothing, the driver guarantees exclusivity.
  always @(posedge clk) begin
    if (S) q_lat <= 1'b1;
    else if (R) q_lat <= 1'b0;
  end

  always_comb begin
    q_fb    = q_lat;
    qbar_fb = ~q_lat;
    case (fb_mode)
      1: begin q_fb = stuck_val; qbar_fb = ~stuck_val; end
      2: begin q_fb = q_lat;     qbar_fb = q_lat;      end
      3: begin q_fb = rand_q;    qbar_fb = rand_qb;    end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (S === 1'b1 && R === 1'b1) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, expected 1", req_ready, n);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic run_txn(input int idx, input txn_t t);
    int   s_cnt = 0, r_cnt = 0, pulses = 0, d_cnt = 0, e_cnt = 0, end_c = 0;
    logic prev = 1'b0;
    wait_ready();
    fb_mode   = t.fb_mode;
    stuck_val = t.stuck_val;
    req_val   = t.val;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (fb_mode == 3) {rand_q, rand_qb} = 2'($urandom);
      if ((S || R) && !prev) begin
        pulses++;
        if (pulses == t.clear_at) fb_mode = 0;
      end
      prev = S || R;
      if (S) s_cnt++;
      if (R) r_cnt++;
      if (done) d_cnt++;
      if (err) e_cnt++;
      if ((done || err) && end_c == 0) end_c = c;
      tick();
    end
    fb_mode = 0;
    check($sformatf("vec%0d_s_cycles", idx), s_cnt, t.exp_s);
    check($sformatf("vec%0d_r_cycles", idx), r_cnt, t.exp_r);
    check($sformatf("vec%0d_pulses", idx), pulses, t.exp_pulses);
    check($sformatf("vec%0d_done", idx), d_cnt, t.exp_done);
    check($sformatf("vec%0d_err", idx), e_cnt, t.exp_err);
    check($sformatf("vec%0d_end_cycle", idx), end_c, t.exp_end);
  endtask

  initial begin
    int d_cnt, e_cnt;

    // Cycle trace for a first-try write of 1 (cycle k = after accept edge + k).
    tr[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tr[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tr[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tr[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SR_DRIVER_VERIFY_EN
    tr[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    //           val   fb  stk  clr   s  r  pl dn er end
    vec[0] = '{1'b1, 0, 1'b0, 0,   2, 0, 1, 1, 0, 5};
    vec[1] = '{1'b0, 0, 1'b0, 0,   0, 2, 1, 1, 0, 5};
    vec[2] = '{1'b0, 1, 1'b1, 0,   0, 8, 4, 0, 1, 17};
    vec[3] = '{1'b0, 1, 1'b1, 3,   0, 6, 3, 1, 0, 13};
    vec[4] = '{1'b1, 1, 1'b0, 0,   8, 0, 4, 0, 1, 17};
    vec[5] = '{1'b1, 2, 1'b0, 0,   8, 0, 4, 0, 1, 17};
`else
    tr[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[0] = '{1'b1, 0, 1'b0, 0,   2, 0, 1, 1, 0, 4};
    vec[1] = '{1'b0, 0, 1'b0, 0,   0, 2, 1, 1, 0, 4};
    vec[2] = '{1'b0, 1, 1'b1, 0,   0, 2, 1, 1, 0, 4};
    vec[3] = '{1'b0, 1, 1'b1, 3,   0, 2, 1, 1, 0, 4};
    vec[4] = '{1'b1, 1, 1'b0, 0,   2, 0, 1, 1, 0, 4};
    vec[5] = '{1'b1, 2, 1'b0, 0,   2, 0, 1, 1, 0, 4};
    vec[6] = '{1'b1, 3, 1'b0, 0,   2, 0, 1, 1, 0, 4};
`endif

    // Reset values while held.
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_S", S, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    #4 rst_n = 1'b1;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Cycle-exact trace.
    req_val   = 1'b1;
    req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("trace%0d_S", c), S, tr[c].s);
      check($sformatf("trace%0d_R", c), R, tr[c].r);
      check($sformatf("trace%0d_busy", c), busy, tr[c].busy);
      check($sformatf("trace%0d_ready", c), req_ready, tr[c].ready);
      check($sformatf("trace%0d_done", c), done, tr[c].done);
      check($sformatf("trace%0d_err", c), err, tr[c].err);
      tick();
      req_valid = 1'b0;
    end

    for (int i = 0; i < N_VEC; i++) run_txn(i, vec[i]);

    // Reset in the first PULSE cycle drops S without a clock edge.
    wait_ready();
    req_val   = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("midrst_S_before", S, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_S_async", S, 0);
    check("midrst_R_async", R, 0);
    check("midrst_busy_async", busy, 0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("midrst_ready_after", req_ready, 1);
    d_cnt = 0;
    e_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) d_cnt++;
      if (err) e_cnt++;
      tick();
    end
    check("midrst_no_done", d_cnt, 0);
    check("midrst_no_err", e_cnt, 0);

    // Back-to-back: second request accepted in the done cycle; val changes while busy are ignored.
    fb_mode   = 0;
    req_val   = 1'b1;
    req_valid = 1'b1;
    wait_done("b2b_first_done");
    check("b2b_ready_in_done", req_ready, 1);
    req_val = 1'b0;
    tick();
    check("b2b_second_R", R, 1);
    check("b2b_second_S", S, 0);
    req_valid = 1'b0;
    req_val   = 1'b1;
    wait_done("b2b_second_done");
    check("b2b_latch_cleared", q_lat, 0);
    tick();

    check("sr_never_both_high", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 2, legal 1..15: S/R drive duration in clock cycles.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal 1..15: idle gap between pulse end and feedback sample.
REQ-003 Parameter MAX_RETRY, default 3, legal 0..7: extra pulse attempts after a failed check.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  1  write request present.
REQ-007 req_val  input  1  target latch state: 1 = set, 0 = reset.
REQ-008 req_ready  output  1  driver can accept a request.
REQ-009 S  output  1  set drive to the external SR latch.
REQ-010 R  output  1  reset drive to the external SR latch.
REQ-011 q_fb  input  1  latch Q read-back, synchronous to clk.
REQ-012 qbar_fb  input  1  latch Qbar read-back, synchronous to clk.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse: write completed and verified.
REQ-015 err  output  1  one-cycle pulse: write failed after all retries.

Function
REQ-016 States IDLE, PULSE, SETTLE, CHECK; all outputs registered.
REQ-017 IDLE: req_ready=1, S=R=0; on req_valid&&req_ready capture req_val, clear retry and cycle counters, go PULSE.
REQ-018 PULSE: S=val, R=~val for exactly PULSE_CYCLES cycles, then SETTLE.
REQ-019 SETTLE: S=R=0 for exactly SETTLE_CYCLES cycles, then CHECK.
REQ-020 CHECK (one cycle): pass iff q_fb==val and qbar_fb==~val; pass -> done=1 next cycle, go IDLE.
REQ-021 CHECK fail with retry_cnt<MAX_RETRY: retry_cnt+1, go PULSE; fail with retry_cnt==MAX_RETRY: err=1 next cycle, go IDLE.
REQ-022 S and R SHALL never be 1 in the same cycle, including across state transitions.
REQ-023 Latency, request accepted at edge 0, first-try pass: S/R high cycles 1..P, low P+1..P+T, CHECK at P+T+1, done at P+T+2 (P=PULSE_CYCLES, T=SETTLE_CYCLES).
REQ-024 done/err are asserted in the first IDLE cycle, coincident with req_ready=1; a request accepted that cycle proceeds normally.
REQ-025 req_valid, req_val, q_fb and qbar_fb outside their sampling states SHALL be ignored; q_fb==qbar_fb at CHECK is a fail.
REQ-026 retry_cnt width is 3 bits; no wrap is possible within legal MAX_RETRY.

Reset
REQ-027 While rst_n=0: state IDLE, S=R=0, done=err=busy=0, req_ready=0, counters cleared.
REQ-028 Reset asserted mid-PULSE SHALL drop S/R to 0 immediately (asynchronously); the in-flight request is discarded with neither done nor err.
REQ-029 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro SR_DRIVER_VERIFY_EN defined: CHECK state, retry and err behaviour as above.
REQ-031 Macro undefined: no CHECK state and no retry counter; SETTLE end produces done next cycle (latency P+T+1); err tied 0; q_fb/qbar_fb unused.

Structure
REQ-032 Package sr_pkg SHALL hold the state enum typedef and the S/R drive encoding constants (SR_HOLD=2'b00, SR_SET=2'b10, SR_RST=2'b01).
REQ-033 One sub-module sr_cycle_counter (4-bit load/decrement, zero flag) SHALL time both PULSE and SETTLE.

Verification
REQ-034 Defaults, req_val=1, latch model follows: S=1 cycles 1-2, S=R=0 cycle 3, CHECK cycle 4, done=1 cycle 5, q_fb=1.
REQ-035 req_val=0 with q_fb stuck at 1, MAX_RETRY=3: four R pulses of 2 cycles each, then err=1 once, done never asserts.
REQ-036 Stuck feedback cleared during second retry: exactly one done pulse, err stays 0, three R pulses observed.
REQ-037 rst_n low in cycle 1 of PULSE: S falls without a clock edge; after release req_ready=1, no done/err.
REQ-038 Back-to-back requests with req_valid held high: second accepted in the done cycle; S/R never simultaneously 1 (assertion over whole run).
REQ-039 SR_DRIVER_VERIFY_EN undefined, defaults: done at cycle 4, err constant 0 with q_fb toggled randomly.
